// File: rtl/pipelined_addsub_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub_accumulator
// Purpose  : WIDTH-bit adder/subtractor with carry/borrow-in. The carry
//            ripples through one SLICE-bit segment per clock. In accumulate
//            mode the accumulator register replaces operand A.
//            Valid/ready handshake on both sides. Throughput is one op per
//            cycle. Latency is STAGES = WIDTH/SLICE cycles without
//            backpressure.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   in_valid   in   operation offered
//   in_ready   out  operation accepted this cycle (when in_valid)
//   a, b       in   operands (a ignored in accumulate mode)
//   sub        in   0 = A + B + cin, 1 = A - B - cin
//   cin        in   carry-in (add) / borrow-in (subtract)
//   acc_mode   in   use accumulator as operand A
//   acc_clear  in   with acc_mode: use 0 as operand A
//   out_valid  out  result held in output register
//   out_ready  in   consumer takes the result
//   sum        out  result
//   cout       out  carry out of MSB (subtract: 1 = no borrow)
//   ovf        out  two's-complement signed overflow
//   acc        out  accumulator value
// Options
//   PIPELINED_ADDSUB_SATURATE_EN : when defined, an overflowing result
//   clamps to the signed max/min. The clamped value also goes to the
//   accumulator.
// ============================================================================
module pipelined_addsub_accumulator #(
    parameter int WIDTH = 32,   // must be a multiple of SLICE
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    input  logic             acc_mode,
    input  logic             acc_clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int STAGES = WIDTH / SLICE;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // Front end: operand selection and subtract conditioning
    // ------------------------------------------------------------------
    logic             w_stall;
    logic             w_accept;
    logic [WIDTH-1:0] w_a_sel;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic [WIDTH-1:0] acc_q;
    logic             acc_busy_q;
    logic             acc_busy_d;

    assign w_stall   = out_valid_q && !out_ready;
    assign in_ready  = !w_stall && !acc_busy_q;
    assign w_accept  = in_valid && in_ready;

    // acc_clear only matters together with acc_mode.
    assign w_a_sel   = acc_mode ? (acc_clear ? '0 : acc_q) : a;
    // Subtract as A + ~B + ~cin so every stage is a plain adder.
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub ? ~cin : cin;

    // ------------------------------------------------------------------
    // Carry-ripple pipeline. Stage k adds slice k. Each stage register
    // holds the finished lower slices, the not-yet-added upper operand
    // slices and the carry. The final stage is not registered here. Its
    // result feeds the output register directly.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_fin_sum;
    logic             w_fin_c;
    logic             w_fin_v;
    logic             w_fin_acc;
    logic             w_fin_a_msb;
    logic             w_fin_b_msb;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SLICE;      // lowest bit handled here
        localparam int REM = WIDTH - LO;     // operand bits still pending

        logic [REM-1:0]      w_a_in;
        logic [REM-1:0]      w_b_in;
        logic                w_c_in;
        logic                w_v_in;
        logic                w_acc_in;
        logic [SLICE:0]      w_add;
        logic [LO+SLICE-1:0] w_s_d;

        if (k == 0) begin : g_first
            assign w_a_in   = w_a_sel;
            assign w_b_in   = w_b_eff;
            assign w_c_in   = w_cin_eff;
            assign w_v_in   = w_accept;
            assign w_acc_in = w_accept && acc_mode;
            assign w_s_d    = w_add[SLICE-1:0];
        end else begin : g_next
            assign w_a_in   = g_stage[k-1].g_reg.a_q;
            assign w_b_in   = g_stage[k-1].g_reg.b_q;
            assign w_c_in   = g_stage[k-1].g_reg.c_q;
            assign w_v_in   = g_stage[k-1].g_reg.v_q;
            assign w_acc_in = g_stage[k-1].g_reg.acc_op_q;
            assign w_s_d    = {w_add[SLICE-1:0], g_stage[k-1].g_reg.s_q};
        end

        assign w_add = {1'b0, w_a_in[SLICE-1:0]}
                     + {1'b0, w_b_in[SLICE-1:0]}
                     + {{SLICE{1'b0}}, w_c_in};

        if (k < LAST) begin : g_reg
            logic [REM-SLICE-1:0] a_q;
            logic [REM-SLICE-1:0] b_q;
            logic [LO+SLICE-1:0]  s_q;
            logic                 c_q;
            logic                 v_q;
            logic                 acc_op_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    a_q      <= '0;
                    b_q      <= '0;
                    s_q      <= '0;
                    c_q      <= 1'b0;
                    v_q      <= 1'b0;
                    acc_op_q <= 1'b0;
                end else if (!w_stall) begin
                    a_q      <= w_a_in[REM-1:SLICE];
                    b_q      <= w_b_in[REM-1:SLICE];
                    s_q      <= w_s_d;
                    c_q      <= w_add[SLICE];
                    v_q      <= w_v_in;
                    acc_op_q <= w_acc_in;
                end
            end
        end else begin : g_fin
            assign w_fin_sum   = w_s_d;
            assign w_fin_c     = w_add[SLICE];
            assign w_fin_v     = w_v_in;
            assign w_fin_acc   = w_acc_in;
            assign w_fin_a_msb = w_a_in[REM-1];
            assign w_fin_b_msb = w_b_in[REM-1];
        end
    end

    // ------------------------------------------------------------------
    // Output register: overflow detection and optional saturation
    // ------------------------------------------------------------------
    logic             w_ovf_d;
    logic [WIDTH-1:0] w_sum_d;
    logic             w_retire;

    // Operand MSBs are taken after B inversion, so one rule covers both
    // add and subtract.
    assign w_ovf_d = (w_fin_a_msb == w_fin_b_msb) && (w_fin_sum[MSB] != w_fin_a_msb);

`ifdef PIPELINED_ADDSUB_SATURATE_EN
    assign w_sum_d = w_ovf_d ? (w_fin_a_msb ? SAT_MIN : SAT_MAX) : w_fin_sum;
`else
    assign w_sum_d = w_fin_sum;
    // The saturation limits are only referenced when clamping is built.
    logic w_unused_sat;
    assign w_unused_sat = ^{SAT_MAX, SAT_MIN};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (!w_stall) begin
            out_valid_q <= w_fin_v;
            sum_q       <= w_sum_d;
            cout_q      <= w_fin_c;
            ovf_q       <= w_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Accumulator and hazard interlock. While an accumulate op is in
    // flight, all input is blocked. The accumulator then takes that op's
    // result as it enters the output register. With a single stage, the
    // accept and the retire happen on the same edge, so busy never sets.
    // ------------------------------------------------------------------
    assign w_retire   = !w_stall && w_fin_v && w_fin_acc;
    assign acc_busy_d = (acc_busy_q || (w_accept && acc_mode)) && !w_retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q      <= '0;
            acc_busy_q <= 1'b0;
        end else begin
            acc_busy_q <= acc_busy_d;
            if (w_retire) begin
                acc_q <= w_sum_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign acc       = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addsub_accumulator
// Purpose  : Bench for pipelined_addsub_accumulator. It runs directed cases
//            and then random traffic. A queue-based arithmetic reference
//            model supplies the expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub_accumulator;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int STAGES = WIDTH / SLICE;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              sub = 1'b0;
    logic              cin = 1'b0;
    logic              acc_mode = 1'b0;
    logic              acc_clear = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              ovf;
    logic [WIDTH-1:0]  acc;

    pipelined_addsub_accumulator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .reset     (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .acc_mode  (acc_mode),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .acc       (acc)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Checking and reference model
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        is_acc;
        logic        seen;
        int          acc_cyc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_acc_latest = '0;   // value the next acc op must use
    logic [31:0] model_acc_ret    = '0;   // value visible on the acc port
    logic        acc_inflight     = 1'b0;
    int          cyc              = 0;
    int          last_stall       = -1;

    // Plain integer arithmetic: unsigned result for sum/carry, signed result
    // for overflow.
    function automatic res_t ref_op(input logic [31:0] A, input logic [31:0] B,
                                    input logic s, input logic c);
        res_t   r;
        longint ua, ub, uc, sa, sb, full, sfull;
        ua = longint'(A);
        ub = longint'(B);
        sa = longint'($signed(A));
        sb = longint'($signed(B));
        uc = c ? 64'sd1 : 64'sd0;
        if (!s) begin
            full   = ua + ub + uc;
            sfull  = sa + sb + uc;
            r.cout = full[32];
        end else begin
            full   = ua - ub - uc;
            sfull  = sa - sb - uc;
            r.cout = (ua >= ub + uc);
        end
        r.sum = full[31:0];
        r.ovf = (sfull > 64'sd2147483647) || (sfull < -64'sd2147483648);
`ifdef PIPELINED_ADDSUB_SATURATE_EN
        if (r.ovf) r.sum = (sfull > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, then observe 1 ns later.
    // This is well clear of the next rising edge.
    task automatic step(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isub, input logic icin, input logic iam,
                        input logic iac, input logic iordy, output logic accepted);
        exp_t        e;
        res_t        r;
        logic [31:0] opa;
        logic [31:0] exp_acc;
        @(negedge clk);
        in_valid  = v;
        a         = ia;
        b         = ib;
        sub       = isub;
        cin       = icin;
        acc_mode  = iam;
        acc_clear = iac;
        out_ready = iordy;
        #1;
        // Output side
        exp_acc = model_acc_ret;
        if (q.size() == 0) begin
            check("spurious_out_valid", out_valid, 1'b0);
        end else if (out_valid) begin
            if (!q[0].seen) begin
                q[0].seen = 1'b1;
                if (last_stall < q[0].acc_cyc)
                    check("latency", cyc - q[0].acc_cyc, STAGES);
                if (q[0].is_acc) acc_inflight = 1'b0;
            end
            check("sum", sum, q[0].sum);
            check("cout", cout, q[0].cout);
            check("ovf", ovf, q[0].ovf);
            if (q[0].is_acc) exp_acc = q[0].sum;
        end
        check("acc", acc, exp_acc);
        // Input side
        if (acc_inflight)
            check("in_ready_acc_busy", in_ready, 1'b0);
        else if (q.size() != 0 && q[0].seen && !iordy)
            check("in_ready_stall", in_ready, 1'b0);
        else if (q.size() == 0)
            check("in_ready_idle", in_ready, 1'b1);
        // Bookkeeping for the coming edge
        if (out_valid && iordy && q.size() != 0) begin
            if (q[0].is_acc) model_acc_ret = q[0].sum;
            void'(q.pop_front());
        end
        if (out_valid && !iordy) last_stall = cyc;
        accepted = v && in_ready;
        if (accepted) begin
            opa = iam ? (iac ? 32'h0 : model_acc_latest) : ia;
            r   = ref_op(opa, ib, isub, icin);
            e.sum = r.sum; e.cout = r.cout; e.ovf = r.ovf;
            e.is_acc = iam; e.seen = 1'b0; e.acc_cyc = cyc;
            q.push_back(e);
            if (iam) begin
                model_acc_latest = r.sum;
                acc_inflight     = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                         input logic icin, input logic iam, input logic iac);
        logic acc_ok;
        acc_ok = 1'b0;
        for (int t = 0; t < 60 && !acc_ok; t++)
            step(1'b1, ia, ib, isub, icin, iam, iac, 1'b1, acc_ok);
        if (!acc_ok) check("issue_timeout", 1'b0, 1'b1);
    endtask

    task automatic idle(input int n, input logic iordy);
        logic dummy;
        for (int t = 0; t < n; t++)
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, iordy, dummy);
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && q.size() != 0; t++) idle(1, 1'b1);
        check("drain_remaining", q.size(), 0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic dummy;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 32'h0);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_acc", acc, 32'h0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Single add: carry across a slice boundary
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Back-to-back wrap and signed overflow
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // Subtract with borrow-in
        issue(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, 1'b0, 1'b0);
        drain();

        // Accumulate: clear, then nine increments
        issue(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++)
            issue(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 1'b0);
        drain();
        check("acc_after_ten", acc, 32'd10);

        // Backpressure with three ops in flight
        step(1'b1, 32'h0000_1000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
        step(1'b1, 32'h0000_2000, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
        step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dummy);
        idle(STAGES + 5, 1'b0);
        check("bp_pending", q.size(), 3);
        drain();

        // Random traffic, including acc ops and backpressure
        for (int i = 0; i < 500; i++) begin
            logic am, ac;
            am = ($urandom_range(0, 9) == 0);
            ac = ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 9) < 7, rnd_val(), rnd_val(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), am, ac, $urandom_range(0, 3) != 0, dummy);
        end
        drain();

        // Reset with two ops mid-pipeline
        issue(32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_acc", acc, 32'h0);
        check("midrst_in_ready", in_ready, 1'b1);
        q.delete();
        model_acc_latest = '0;
        model_acc_ret    = '0;
        acc_inflight     = 1'b0;
        last_stall       = -1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = cyc + 3;
        idle(2 * STAGES + 4, 1'b1);

        // Pipeline still works after reset
        issue(32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
